// File: rtl/fifo_gen_pkg.sv
// Shared types and elaboration helpers for the parametrised FIFO.
package fifo_gen_pkg;

  typedef enum logic {FIFO_STD = 1'b0, FIFO_FWFT = 1'b1} fifo_mode_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // One parity bit per started byte of data.
  function automatic int parity_bits(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/fifo_gen_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port, block-RAM style.
module fifo_gen_ram
  import fifo_gen_pkg::*;
#(
  parameter int Width     = 9,
  parameter int Depth     = 16,
  parameter int AddrWidth = clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [Width-1:0]     wdata_i,
  input  logic                 re_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [Width-1:0]     rdata_o
);
  logic [Width-1:0] mem [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Reset only touches the output register, which maps onto the RAM output-latch reset.
  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_gen_param.sv
// Parametrised synchronous block-RAM FIFO with standard or first-word-fall-through read.
// Define FIFO_GEN_PARITY_EN to store and recheck one even-parity bit per data byte.
module fifo_gen_param
  import fifo_gen_pkg::*;
#(
  parameter int Width         = 9,
  parameter int Depth         = 4096,
  parameter int FirstWordFall = 0,
  parameter int CountWidth    = clog2(Depth) + 1
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic [Width-1:0]      din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [CountWidth-1:0] prog_full_thresh,
  input  logic [CountWidth-1:0] prog_empty_thresh,
  input  logic                  clr_err,
  output logic [Width-1:0]      dout,
  output logic                  valid,
  output logic                  full,
  output logic                  empty,
  output logic                  prog_full,
  output logic                  prog_empty,
  output logic [CountWidth-1:0] data_count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  parity_err
);
  localparam int AW = clog2(Depth);
  localparam fifo_mode_e MODE = (FirstWordFall != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [CountWidth-1:0] DEPTH_C = CountWidth'(Depth);
`ifdef FIFO_GEN_PARITY_EN
  localparam int PW = parity_bits(Width);
  localparam int RW = Width + PW;
`else
  localparam int RW = Width;
`endif

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic                  full_q, pfull_q, pempty_q, ovf_q, ovf_d, udf_q, udf_d;
  logic                  wr_acc, rd_acc, rd_udf, ram_re;
  logic [RW-1:0]         wdata, rdata;

`ifdef FIFO_GEN_PARITY_EN
  logic          chk, perr_q, par_hit;
  logic [RW-1:0] out_word;

  function automatic logic [PW-1:0] gen_par(input logic [Width-1:0] d);
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < Width; i++) p[i/8] = p[i/8] ^ d[i];
    return p;
  endfunction

  assign wdata = {gen_par(din), din};
`else
  assign wdata = din;
`endif

  assign wr_acc = wr_en & ~full_q;

  always_comb begin
    count_d = count_q;
    if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
    else if (!wr_acc && rd_acc) count_d = count_q - 1'b1;
    wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = ram_re ? rd_ptr_q + 1'b1 : rd_ptr_q;
    ovf_d    = (ovf_q & ~clr_err) | (wr_en & full_q);
    udf_d    = (udf_q & ~clr_err) | rd_udf;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      pfull_q  <= 1'b0;
      pempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_C);
      pfull_q  <= (count_d >= prog_full_thresh);
      pempty_q <= (count_d <= prog_empty_thresh);
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_gen_ram #(.Width(RW), .Depth(Depth)) u_ram (
    .clk_i   (clk),
    .rst_i   (srst),
    .we_i    (wr_acc & ~srst),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .re_i    (ram_re & ~srst),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  generate
    if (MODE == FIFO_STD) begin : g_std
      logic valid_q, empty_q;
      assign rd_acc = rd_en & ~empty_q;
      assign rd_udf = rd_en & empty_q;
      assign ram_re = rd_acc;
      always_ff @(posedge clk) begin
        if (srst) begin
          valid_q <= 1'b0;
          empty_q <= 1'b1;
        end else begin
          valid_q <= rd_acc;
          empty_q <= (count_d == '0);
        end
      end
      assign valid = valid_q;
      assign empty = empty_q;
      assign dout  = rdata[Width-1:0];
`ifdef FIFO_GEN_PARITY_EN
      assign chk      = valid_q;
      assign out_word = rdata;
`endif
    end else begin : g_fwft
      // Two-stage prefetch: RAM output register (stage 1) feeding dout_q (stage 2).
      logic [RW-1:0]         dout_q;
      logic                  valid_q, vld1_q, load, wr_vis_q;
      logic [CountWidth-1:0] avail_q;
      assign rd_acc = rd_en & valid_q;
      assign rd_udf = rd_en & ~valid_q;
      assign load   = vld1_q & (~valid_q | rd_acc);
      assign ram_re = (avail_q != '0) & (~vld1_q | load);
      // Written words become fetchable one cycle after their write edge.
      always_ff @(posedge clk) begin
        if (srst) begin
          dout_q   <= '0;
          valid_q  <= 1'b0;
          vld1_q   <= 1'b0;
          avail_q  <= '0;
          wr_vis_q <= 1'b0;
        end else begin
          wr_vis_q <= wr_acc;
          avail_q  <= avail_q + CountWidth'(wr_vis_q) - CountWidth'(ram_re);
          vld1_q   <= ram_re | (vld1_q & ~load);
          valid_q  <= load | (valid_q & ~rd_acc);
          if (load) dout_q <= rdata;
        end
      end
      assign valid = valid_q;
      assign empty = ~valid_q;
      assign dout  = dout_q[Width-1:0];
`ifdef FIFO_GEN_PARITY_EN
      logic chk_q;
      always_ff @(posedge clk) begin
        if (srst) chk_q <= 1'b0;
        else      chk_q <= load;
      end
      assign chk      = chk_q;
      assign out_word = dout_q;
`endif
    end
  endgenerate

`ifdef FIFO_GEN_PARITY_EN
  // The live check is ORed in so the flag rises together with the word's valid.
  assign par_hit = chk & (gen_par(out_word[Width-1:0]) != out_word[RW-1:Width]);
  always_ff @(posedge clk) begin
    if (srst) perr_q <= 1'b0;
    else      perr_q <= (perr_q & ~clr_err) | par_hit;
  end
  assign parity_err = perr_q | par_hit;
`else
  assign parity_err = 1'b0;
`endif

  assign full       = full_q;
  assign prog_full  = pfull_q;
  assign prog_empty = pempty_q;
  assign data_count = count_q;
  assign overflow   = ovf_q;
  assign underflow  = udf_q;

endmodule

// File: tb/tb_fifo_gen_param.sv
// Bench for fifo_gen_param: standard Depth=16, FWFT Depth=16 and standard Depth=4 instances.
module tb_fifo_gen_param;
  localparam int W = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic srst, clr_err;
  logic [W-1:0] a_din, a_dout, b_din, b_dout, c_din, c_dout;
  logic a_wr, a_rd, a_valid, a_full, a_empty, a_pf, a_pe, a_ovf, a_udf, a_perr;
  logic b_wr, b_rd, b_valid, b_full, b_empty, b_pf, b_pe, b_ovf, b_udf, b_perr;
  logic c_wr, c_rd, c_valid, c_full, c_empty, c_pf, c_pe, c_ovf, c_udf, c_perr;
  logic [4:0] a_pft, a_pet, a_cnt, b_pft, b_pet, b_cnt;
  logic [2:0] c_pft, c_pet, c_cnt;

  fifo_gen_param #(.Width(W), .Depth(16), .FirstWordFall(0)) dut_a (
    .clk(clk), .srst(srst), .din(a_din), .wr_en(a_wr), .rd_en(a_rd),
    .prog_full_thresh(a_pft), .prog_empty_thresh(a_pet), .clr_err(clr_err),
    .dout(a_dout), .valid(a_valid), .full(a_full), .empty(a_empty),
    .prog_full(a_pf), .prog_empty(a_pe), .data_count(a_cnt),
    .overflow(a_ovf), .underflow(a_udf), .parity_err(a_perr));

  fifo_gen_param #(.Width(W), .Depth(16), .FirstWordFall(1)) dut_b (
    .clk(clk), .srst(srst), .din(b_din), .wr_en(b_wr), .rd_en(b_rd),
    .prog_full_thresh(b_pft), .prog_empty_thresh(b_pet), .clr_err(clr_err),
    .dout(b_dout), .valid(b_valid), .full(b_full), .empty(b_empty),
    .prog_full(b_pf), .prog_empty(b_pe), .data_count(b_cnt),
    .overflow(b_ovf), .underflow(b_udf), .parity_err(b_perr));

  fifo_gen_param #(.Width(W), .Depth(4), .FirstWordFall(0)) dut_c (
    .clk(clk), .srst(srst), .din(c_din), .wr_en(c_wr), .rd_en(c_rd),
    .prog_full_thresh(c_pft), .prog_empty_thresh(c_pet), .clr_err(clr_err),
    .dout(c_dout), .valid(c_valid), .full(c_full), .empty(c_empty),
    .prog_full(c_pf), .prog_empty(c_pe), .data_count(c_cnt),
    .overflow(c_ovf), .underflow(c_udf), .parity_err(c_perr));

  typedef struct {
    logic       wr, rd, clr;
    logic [4:0] cnt;
    logic       full, empty, pf, pe, vld, ovf, udf;
  } vec_t;

  vec_t         tbl[$];
  logic [W-1:0] q_a[$], q_b[$], q_c[$];
  int           checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_miss(input string name, input logic [W-1:0] act);
    checks++;
    errors++;
    $display("FAIL %s: output word %0h with empty scoreboard at %0t", name, act, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected flags follow from the expected count with thresholds 12 / 3.
  task automatic add(input logic wr, input logic rd, input logic clr, input int cnt,
                     input logic vld, input logic ovf, input logic udf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.clr = clr; v.cnt = 5'(cnt);
    v.full = (cnt == 16); v.empty = (cnt == 0);
    v.pf = (cnt >= 12); v.pe = (cnt <= 3);
    v.vld = vld; v.ovf = ovf; v.udf = udf;
    tbl.push_back(v);
  endtask

  // FWFT and Depth=4 scoreboards pop as the DUT presents/consumes words.
  always @(negedge clk) begin
    if (!srst && b_valid && b_rd) begin
      if (q_b.size() == 0) sb_miss("b_sb", b_dout);
      else chk("b_dout", b_dout, q_b.pop_front());
    end
    if (!srst && c_valid) begin
      if (q_c.size() == 0) sb_miss("c_sb", c_dout);
      else chk("c_dout", c_dout, q_c.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    logic prev_full;
    srst = 1'b1; clr_err = 1'b0;
    a_pft = 5'd12; a_pet = 5'd3; b_pft = 5'd16; b_pet = 5'd0; c_pft = 3'd4; c_pet = 3'd0;
    a_din = '0; b_din = '0; c_din = '0;
    a_wr = 1'b1; a_rd = 1'b1; b_wr = 1'b1; b_rd = 1'b1; c_wr = 1'b1; c_rd = 1'b1;

    for (int i = 0; i < 17; i++) add(1, 0, 0, (i < 16) ? i + 1 : 16, 0, i == 16, 0);
    for (int j = 0; j < 16; j++) add(0, 1, 0, 15 - j, 1, 1, 0);
    add(0, 1, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0);

    // Requests during reset must be ignored.
    tick(); tick();
    chk("rst_a_count", a_cnt, 0);   chk("rst_a_full", a_full, 0);
    chk("rst_a_empty", a_empty, 1); chk("rst_a_pf", a_pf, 0);
    chk("rst_a_pe", a_pe, 1);       chk("rst_a_valid", a_valid, 0);
    chk("rst_a_dout", a_dout, 0);   chk("rst_a_ovf", a_ovf, 0);
    chk("rst_a_udf", a_udf, 0);     chk("rst_b_valid", b_valid, 0);
    chk("rst_b_empty", b_empty, 1); chk("rst_b_dout", b_dout, 0);
    srst = 1'b0;
    a_wr = 1'b0; a_rd = 1'b0; b_wr = 1'b0; b_rd = 1'b0; c_wr = 1'b0; c_rd = 1'b0;

    prev_full = 1'b0;
    foreach (tbl[k]) begin
      a_wr = tbl[k].wr; a_rd = tbl[k].rd; clr_err = tbl[k].clr; a_din = W'(k);
      if (a_wr && !prev_full) q_a.push_back(a_din);
      prev_full = tbl[k].full;
      tick();
      chk("a_count", a_cnt, tbl[k].cnt); chk("a_full", a_full, tbl[k].full);
      chk("a_empty", a_empty, tbl[k].empty); chk("a_prog_full", a_pf, tbl[k].pf);
      chk("a_prog_empty", a_pe, tbl[k].pe); chk("a_valid", a_valid, tbl[k].vld);
      chk("a_overflow", a_ovf, tbl[k].ovf); chk("a_underflow", a_udf, tbl[k].udf);
      if (a_valid) begin
        if (q_a.size() == 0) sb_miss("a_sb", a_dout);
        else chk("a_dout", a_dout, q_a.pop_front());
      end
    end
    a_wr = 1'b0; a_rd = 1'b0; clr_err = 1'b0;
    a_pft = 5'd0; tick(); chk("a_thresh_change", a_pf, 1);
    a_pft = 5'd17; tick(); chk("a_thresh_above_depth", a_pf, 0);

    // FWFT first-word latency.
    b_din = 9'h1A5; b_wr = 1'b1; q_b.push_back(b_din); tick(); b_wr = 1'b0;
    chk("b_count_w", b_cnt, 1); chk("b_valid_c1", b_valid, 0);
    tick(); chk("b_valid_c2", b_valid, 0);
    tick(); chk("b_valid_c3", b_valid, 0); chk("b_empty_c3", b_empty, 1);
    tick(); chk("b_valid_first", b_valid, 1); chk("b_dout_first", b_dout, 9'h1A5);
    chk("b_empty_first", b_empty, 0);
    b_rd = 1'b1; tick(); b_rd = 1'b0;
    chk("b_valid_pop", b_valid, 0); chk("b_count_pop", b_cnt, 0);

    // FWFT streaming at half fill.
    for (int i = 0; i < 8; i++) begin
      b_din = W'(9'h40 + i); b_wr = 1'b1; q_b.push_back(b_din); tick();
    end
    b_wr = 1'b0;
    repeat (4) tick();
    chk("b_half_valid", b_valid, 1); chk("b_half_count", b_cnt, 8);
    b_wr = 1'b1; b_rd = 1'b1;
    for (int i = 0; i < 100; i++) begin
      b_din = W'($urandom); q_b.push_back(b_din); tick();
      chk("b_stream_valid", b_valid, 1); chk("b_stream_count", b_cnt, 8);
    end
    b_wr = 1'b0;
    for (int i = 0; i < 40 && q_b.size() > 0; i++) tick();
    b_rd = 1'b0;
    tick();
    chk("b_sb_drained", q_b.size(), 0); chk("b_empty_end", b_empty, 1);
    chk("b_count_end", b_cnt, 0); chk("b_underflow", b_udf, 0); chk("b_overflow", b_ovf, 0);

    // Depth=4 pointer wrap with simultaneous read and write.
    for (int i = 0; i < 2; i++) begin
      c_din = W'(9'h100 + i); c_wr = 1'b1; q_c.push_back(c_din); tick();
    end
    c_rd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      c_din = W'(9'h20 + i); q_c.push_back(c_din); tick();
      chk("c_full", c_full, 0); chk("c_count", c_cnt, 2); chk("c_valid", c_valid, 1);
    end
    c_wr = 1'b0;
    tick(); tick();
    c_rd = 1'b0;
    tick(); tick();
    chk("c_sb_drained", q_c.size(), 0); chk("c_empty_end", c_empty, 1);
    chk("c_count_end", c_cnt, 0); chk("c_underflow", c_udf, 0);

`ifdef FIFO_GEN_PARITY_EN
    srst = 1'b1; tick(); srst = 1'b0;
    a_din = 9'h055; a_wr = 1'b1; tick(); a_wr = 1'b0;
    dut_a.u_ram.mem[0][0] = ~dut_a.u_ram.mem[0][0];
    a_rd = 1'b1; tick(); a_rd = 1'b0;
    chk("a_par_valid", a_valid, 1); chk("a_parity_err", a_perr, 1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("a_parity_clr", a_perr, 0);
`else
    chk("a_parity_off", a_perr, 0);
`endif
    chk("b_parity", b_perr, 0); chk("c_parity", c_perr, 0);
    chk("a_sb_drained", q_a.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
